// File: rtl/ir_queue.sv
// ir_queue: LC-3b instruction register as a DEPTH-entry FIFO of {instr, pc}.
// Lets fetch run ahead of decode; head fields are decoded combinationally.
module ir_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               opcode,
  output logic [2:0]               dest,
  output logic [2:0]               src1,
  output logic [2:0]               src2,
  output logic [10:0]              offset11,
  output logic [8:0]               offset9,
  output logic [5:0]               offset6,
  output logic [4:0]               imm5,
  output logic [3:0]               imm4,
  output logic                     instruction5,
  output logic                     instruction11
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDW  = 4'h6,
    OP_STW  = 4'h7,
    OP_RTI  = 4'h8,
    OP_XOR  = 4'h9,
    OP_R10  = 4'hA,
    OP_R11  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef struct packed {
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  entry_t        head;
  lc3b_opcode    head_op;

  // Ready/valid depend only on registered count, never on the other side.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Gate the head so stale entries left by a flush stay invisible.
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  assign head_op       = lc3b_opcode'(out_instr[15:12]);
  assign opcode        = head_op;
  assign dest          = out_instr[11:9];
  assign src1          = out_instr[8:6];
  assign src2          = out_instr[2:0];
  assign offset11      = out_instr[10:0];
  assign offset9       = out_instr[8:0];
  assign offset6       = out_instr[5:0];
  assign imm5          = out_instr[4:0];
  assign imm4          = out_instr[3:0];
  assign instruction5  = out_instr[5];
  assign instruction11 = out_instr[11];

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: vector table, hand sequences and a random run
// against a queue-based model of the instruction FIFO.
module tb_ir_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 0;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [CW-1:0]   count;
  logic [3:0]      opcode;
  logic [2:0]      dest;
  logic [2:0]      src1;
  logic [2:0]      src2;
  logic [10:0]     offset11;
  logic [8:0]      offset9;
  logic [5:0]      offset6;
  logic [4:0]      imm5;
  logic [3:0]      imm4;
  logic            instruction5;
  logic            instruction11;

  int total = 0;
  int bad   = 0;

  ir_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset11(offset11), .offset9(offset9), .offset6(offset6),
    .imm5(imm5), .imm4(imm4),
    .instruction5(instruction5), .instruction11(instruction11)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        fl;
    logic        iv;
    logic [15:0] ii;
    logic        ro;
    int          ec;
    logic        eov;
    logic        eir;
    logic [15:0] ei;
  } vec_t;

  vec_t vt[$];

  function automatic logic [15:0] pcof(logic [15:0] w);
    return w ^ 16'hA5A5;
  endfunction

  function automatic logic [49:0] fexp(logic [15:0] w);
    return {w[15:12], w[11:9], w[8:6], w[2:0], w[10:0],
            w[8:0], w[5:0], w[4:0], w[3:0], w[5], w[11]};
  endfunction

  function automatic logic [49:0] fact();
    return {opcode, dest, src1, src2, offset11, offset9,
            offset6, imm5, imm4, instruction5, instruction11};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic f, logic iv, logic [15:0] ii,
                       logic [15:0] ip, logic ro);
    reset_n   = r;
    flush     = f;
    in_valid  = iv;
    in_instr  = ii;
    in_pc     = ip;
    out_ready = ro;
  endtask

  task automatic add(logic r, logic f, logic iv, logic [15:0] ii,
                     logic ro, int ec, logic eov, logic eir,
                     logic [15:0] ei);
    vec_t v;
    v.rst_n = r; v.fl = f; v.iv = iv; v.ii = ii; v.ro = ro;
    v.ec = ec; v.eov = eov; v.eir = eir; v.ei = ei;
    vt.push_back(v);
  endtask

  task automatic chk_head(string tag, int ec, logic eov,
                          logic eir, logic [15:0] ei,
                          logic [15:0] ep);
    chk({tag, ".count"}, 64'(count), 64'(ec));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(eov));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(eir));
    chk({tag, ".instr"}, 64'(out_instr), 64'(ei));
    chk({tag, ".pc"}, 64'(out_pc), 64'(ep));
    chk({tag, ".fields"}, 64'(fact()), 64'(fexp(ei)));
  endtask

  logic [31:0] q[$];

  initial begin
    drive(0, 0, 0, 16'h0, 16'h0, 0);
    step();
    step();
    chk_head("reset", 0, 0, 1, 16'h0, 16'h0);

    // Push 0x1234 and check the decoded head fields.
    drive(1, 0, 1, 16'h1234, 16'h3000, 0);
    step();
    drive(1, 0, 0, 16'h0, 16'h0, 0);
    chk("p1.valid", 64'(out_valid), 64'd1);
    chk("p1.opcode", 64'(opcode), 64'h1);
    chk("p1.dest", 64'(dest), 64'd1);
    chk("p1.src1", 64'(src1), 64'd0);
    chk("p1.src2", 64'(src2), 64'd4);
    chk("p1.imm5", 64'(imm5), 64'h14);
    chk("p1.i5", 64'(instruction5), 64'd1);
    chk("p1.pc", 64'(out_pc), 64'h3000);
    chk("p1.count", 64'(count), 64'd1);
    drive(1, 0, 0, 16'h0, 16'h0, 1);
    step();
    chk("p1.drain", 64'(count), 64'd0);

    // Vector table: fill/drain, full push+pop, flush and reset rows.
    add(1, 0, 1, 16'h0A01, 0, 1, 1, 1, 16'h0A01);
    add(1, 0, 1, 16'h0A02, 0, 2, 1, 1, 16'h0A01);
    add(1, 0, 1, 16'h0A03, 0, 3, 1, 1, 16'h0A01);
    add(1, 0, 1, 16'h0A04, 0, 4, 1, 0, 16'h0A01);
    add(1, 0, 1, 16'hFFFF, 0, 4, 1, 0, 16'h0A01);
    add(1, 0, 0, 16'h0000, 1, 3, 1, 1, 16'h0A02);
    add(1, 0, 0, 16'h0000, 1, 2, 1, 1, 16'h0A03);
    add(1, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h0A04);
    add(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000);
    add(1, 0, 1, 16'h0B01, 0, 1, 1, 1, 16'h0B01);
    add(1, 0, 1, 16'h0B02, 0, 2, 1, 1, 16'h0B01);
    add(1, 0, 1, 16'h0B03, 0, 3, 1, 1, 16'h0B01);
    add(1, 0, 1, 16'h0B04, 0, 4, 1, 0, 16'h0B01);
    add(1, 0, 1, 16'hFFFF, 1, 3, 1, 1, 16'h0B02);
    add(1, 0, 1, 16'hC0DE, 0, 4, 1, 0, 16'h0B02);
    add(1, 0, 0, 16'h0000, 1, 3, 1, 1, 16'h0B03);
    add(1, 0, 0, 16'h0000, 1, 2, 1, 1, 16'h0B04);
    add(1, 0, 0, 16'h0000, 1, 1, 1, 1, 16'hC0DE);
    add(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000);
    add(1, 0, 1, 16'h1111, 0, 1, 1, 1, 16'h1111);
    add(1, 1, 1, 16'h2222, 1, 0, 0, 1, 16'h0000);
    add(1, 0, 1, 16'h3333, 0, 1, 1, 1, 16'h3333);
    add(0, 0, 1, 16'h4444, 1, 0, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].fl, vt[i].iv, vt[i].ii,
            pcof(vt[i].ii), vt[i].ro);
      step();
      chk_head($sformatf("vec%0d", i), vt[i].ec, vt[i].eov,
               vt[i].eir, vt[i].ei,
               vt[i].eov ? pcof(vt[i].ei) : 16'h0);
    end

    // Steady stream across pointer wrap.
    drive(1, 0, 1, 16'h7000, 16'h8000, 0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 1, 16'h7000 + 16'(i), 16'h8000 + 16'(i), 1);
      step();
      chk_head($sformatf("strm%0d", i), 1, 1, 1,
               16'h7000 + 16'(i), 16'h8000 + 16'(i));
    end
    drive(1, 0, 0, 16'h0, 16'h0, 1);
    step();

    // Flush with 3 entries plus a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 16'h0C00 + 16'(i), 16'h0, 0);
      step();
    end
    chk("fl.pre", 64'(count), 64'd3);
    drive(1, 1, 1, 16'hBEEF, 16'h1234, 1);
    step();
    chk_head("fl", 0, 0, 1, 16'h0, 16'h0);
    drive(1, 0, 1, 16'h5FC0, 16'h4321, 0);
    step();
    drive(1, 0, 0, 16'h0, 16'h0, 0);
    chk("fl.instr", 64'(out_instr), 64'h5FC0);
    chk("fl.off6", 64'(offset6), 64'h0);
    chk("fl.src1", 64'(src1), 64'd7);
    chk("fl.dest", 64'(dest), 64'd7);
    chk("fl.count", 64'(count), 64'd1);

    // Reset mid-stream with 2 entries while pushing and popping.
    drive(1, 0, 1, 16'h0D00, 16'h0, 0);
    step();
    drive(0, 0, 1, 16'h0D01, 16'h0, 1);
    step();
    drive(1, 0, 0, 16'h0, 16'h0, 0);
    chk_head("rst", 0, 0, 1, 16'h0, 16'h0);
    step();
    chk_head("rst2", 0, 0, 1, 16'h0, 16'h0);

    // Random run against a queue model.
    q.delete();
    for (int n = 0; n < 600; n++) begin
      logic r, f, iv, ro, mr, mv;
      logic [15:0] ii, ip, ei, ep;
      r  = $urandom_range(0, 59) != 0;
      f  = $urandom_range(0, 29) == 0;
      iv = $urandom_range(0, 3) != 0;
      ro = $urandom_range(0, 2) != 0;
      ii = 16'($urandom);
      ip = 16'($urandom);
      drive(r, f, iv, ii, ip, ro);
      mr = q.size() < DEPTH;
      mv = q.size() != 0;
      #1;
      chk($sformatf("rnd%0d.pre_ready", n), 64'(in_ready), 64'(mr));
      if (!r || f) begin
        q.delete();
      end else begin
        if (mv && ro) void'(q.pop_front());
        if (iv && mr) q.push_back({ii, ip});
      end
      step();
      ei = q.size() != 0 ? q[0][31:16] : 16'h0;
      ep = q.size() != 0 ? q[0][15:0] : 16'h0;
      chk_head($sformatf("rnd%0d", n), q.size(), q.size() != 0,
               q.size() < DEPTH, ei, ep);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
